// File: rtl/game_pkg.sv
// Shared game definitions: enemy kinds, point values, run/over states and
// record widths used by the game logic and the display path.
package game_pkg;

  localparam int unsigned ENEMY_COUNT   = 8;
  localparam int unsigned KIND_W        = 2;
  localparam int unsigned ENEMY_STATE_W = 19;
  localparam int unsigned SHIP_STATE_W  = 28;
  localparam int unsigned POINTS_W      = 4;

  typedef enum logic [KIND_W-1:0] {
    KIND_GRUNT   = 2'd0,
    KIND_SOLDIER = 2'd1,
    KIND_ELITE   = 2'd2,
    KIND_BOSS    = 2'd3
  } enemy_kind_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_OVER = 1'b1
  } game_state_e;

  // Points awarded for destroying one enemy of the given kind.
  function automatic logic [POINTS_W-1:0] kind_points(input enemy_kind_e kind);
    logic [POINTS_W-1:0] pts;
    case (kind)
      KIND_GRUNT:   pts = POINTS_W'(1);
      KIND_SOLDIER: pts = POINTS_W'(2);
      KIND_ELITE:   pts = POINTS_W'(4);
      default:      pts = POINTS_W'(8);
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/pulse_stretch.sv
// Stretches a one-cycle trigger into a level that lasts HOLD frame ticks.
// A trigger reloads the countdown; clear wins over everything.
module pulse_stretch #(
  parameter int unsigned HOLD = 30
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic trig,
  input  logic tick,
  output logic out
);

  localparam int unsigned CNT_W = $clog2(HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (trig) begin
      cnt_d = HOLD_VAL;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Output is registered from the next count so it tracks the counter exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      out   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      out   <= (cnt_d != '0);
    end
  end

endmodule

// File: rtl/game_stats.sv
// Scoring and status stage: saturating score, best score, alive-enemy count,
// stretched collision indicator and run/over phase for the display driver.
module game_stats
  import game_pkg::*;
#(
  parameter int unsigned HOLD_FRAMES = 30,
  parameter int unsigned SCORE_W     = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tick,
  input  logic                          restart,
  input  logic                          game_over,
  input  logic [ENEMY_COUNT-1:0]        enemy_alive,
  input  logic [ENEMY_COUNT-1:0]        kill_mask,
  input  logic [KIND_W*ENEMY_COUNT-1:0] kill_kind,
  input  logic                          hit,
  output logic [SCORE_W-1:0]            score,
  output logic [SCORE_W-1:0]            best,
  output logic [3:0]                    enemy_count,
  output logic                          collision,
  output logic                          over
);

  localparam int unsigned DELTA_W = 7;
  localparam int unsigned COUNT_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  game_state_e          state_q;
  game_state_e          state_d;
  logic [SCORE_W-1:0]   score_d;
  logic [SCORE_W-1:0]   best_d;
  logic [SCORE_W-1:0]   score_next;
  logic [SCORE_W:0]     score_sum;
  logic [DELTA_W-1:0]   delta;
  logic [COUNT_W-1:0]   count_d;
  logic                 over_d;
  logic                 hit_run;

  // Points from every slot killed this cycle.
  always_comb begin
    delta = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      if (kill_mask[i]) begin
        delta = delta + DELTA_W'(kind_points(enemy_kind_e'(kill_kind[KIND_W*i +: KIND_W])));
      end
    end
  end

  // Sum carries one extra bit so overflow is detectable before clamping.
  assign score_sum  = {1'b0, score} + (SCORE_W+1)'(delta);
  assign score_next = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];

  always_comb begin
    count_d = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) begin
      if (enemy_alive[i]) begin
        count_d = count_d + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Restart is applied last: it clears the score after any best update and
  // only pulls OVER back to RUN.
  always_comb begin
    state_d = state_q;
    score_d = score;
    best_d  = best;
    if (state_q == ST_RUN) begin
      score_d = score_next;
      if (game_over) begin
        state_d = ST_OVER;
        if (score_next > best) begin
          best_d = score_next;
        end
      end
    end
    if (restart) begin
      score_d = '0;
      if (state_q == ST_OVER) begin
        state_d = ST_RUN;
      end
    end
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score       <= '0;
      best        <= '0;
      enemy_count <= '0;
      over        <= 1'b0;
    end else begin
      score       <= score_d;
      best        <= best_d;
      enemy_count <= count_d;
      over        <= over_d;
    end
  end

  assign hit_run = hit && (state_q == ST_RUN);

  pulse_stretch #(
    .HOLD (HOLD_FRAMES)
  ) u_collision (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .trig  (hit_run),
    .tick  (tick),
    .out   (collision)
  );

endmodule

// File: doc/game_stats.md
# game_stats

Upstream scoring and status stage feeding the board display driver. Consumes per-frame kill and hit events from the game logic and the enemy alive mask. Produces the registered `score`, `enemy_count` and `collision` signals that the display block renders on HEX0/HEX2–HEX4 and LEDR[0]. Also tracks run/over phase and a best-score register.

## Interface
- `HOLD_FRAMES`, 30: number of frame ticks `collision` stays high after a hit.
- `SCORE_W`, 10: score width; saturation value is 2^SCORE_W−1 (1023).
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle frame strobe.
- `restart`  in  1  synchronous new-game request, one-cycle pulse.
- `game_over`  in  1  level from game logic, spaceship destroyed.
- `enemy_alive`  in  8  alive bit per enemy slot.
- `kill_mask`  in  8  one-cycle pulse per slot killed this cycle; any number of bits may be set.
- `kill_kind`  in  16  2-bit kind per slot; slot i uses bits [2i+1:2i].
- `hit`  in  1  one-cycle spaceship-collision pulse.
- `score`  out  SCORE_W  current score, saturating.
- `best`  out  SCORE_W  highest score of any finished game.
- `enemy_count`  out  4  registered popcount of `enemy_alive`, range 0–8.
- `collision`  out  1  stretched hit indicator.
- `over`  out  1  high in state OVER.

## Operation
- State machine with two states: RUN and OVER.
  - Reset state is RUN.
  - RUN→OVER when `game_over`=1.
  - OVER→RUN on `restart`.
  - `restart` in RUN also clears the game. It never changes `best`.
- Scoring applies in RUN only.
  - Each cycle, delta = sum of points over all set `kill_mask` bits.
  - Points per kind: 0→1, 1→2, 2→4, 3→8. Maximum delta is 64.
  - score_next = min(score + delta, 1023). The sum is computed at SCORE_W+1 bits before clamping.
  - Kills in OVER are ignored.
- `best` is updated on the RUN→OVER transition: best = max(best, score_next).
  - score_next includes any kills in that same cycle.
- `restart` clears `score` and the hold counter.
  - It is evaluated after `game_over`: if both are high in OVER, the next state is RUN.
  - If both are high in RUN, the block goes to OVER. `best` is updated with the pre-clear score, and `score` is then cleared.
- Collision uses a hold counter `hold`, width clog2(HOLD_FRAMES+1).
  - `hit` in RUN loads HOLD_FRAMES.
  - Otherwise, `tick` with `hold`≠0 decrements it.
  - `collision` = (`hold`≠0). When `hit` and `tick` occur in the same cycle, the load wins.
  - `hit` in OVER is ignored; an existing countdown continues.
- `enemy_count` is the registered popcount of `enemy_alive` every cycle, in either state.

## Timing
- All outputs are registered and update on the clk edge after the causing input: 1-cycle latency.
- `collision` rises 1 cycle after `hit`. It stays high for HOLD_FRAMES subsequent ticks and falls on the edge consuming the HOLD_FRAMES-th tick.
- Reset values: `score`=0, `best`=0, `enemy_count`=0, `collision`=0, `over`=0, state RUN, `hold`=0.
- Reset asserted mid-game clears everything at once, including `best`.
- No handshakes. All event inputs are single-cycle pulses sampled each clk.

## Structure
- Shared package `game_pkg`:
  - enemy kind encoding;
  - kind→points function;
  - `ENEMY_COUNT`=8;
  - state-width constants used by the game logic and the display (19-bit enemy record, 28-bit spaceship record).
- Sub-module `pulse_stretch`, parameter HOLD, with inputs clk, reset, trig, tick and output out. It holds the collision counter.
- Scoring adder tree, clamp, popcount and FSM stay inline.

## Test plan
- Reset, then kill_mask=8'h01 with kind 0 → score=1 one cycle later; enemy_alive=8'hA5 → enemy_count=4.
- Same-cycle kill_mask=8'hFF, all kinds 3 → score increments by 64. Repeat from score=1000 → score=1023, then stays 1023 on further kills.
- hit pulse, then 30 ticks → collision high from the cycle after hit until the 30th tick. A second hit at tick 10 reloads the counter, so collision stays high for 30 more ticks.
- Score 37 with game_over=1 and a kind-2 kill in the same cycle → over=1, best=41. Subsequent kills leave score=41.
- In OVER, restart=1 → over=0, score=0, best=41. Next game ends at 20 → best stays 41.
- reset asserted asynchronously mid-count (hold=12, score=500) → all outputs read 0 before the next clk edge.
